// File: rtl/line_scheduler.sv
// Double-buffered line table: requesters fill a shadow table during the frame,
// and the whole table is copied to the renderer-facing active table on the frame boundary.
module line_scheduler #(
   parameter int H_LAST = 1649,
   parameter int V_LAST = 749
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic [1:0]  req_valid_in,
   output logic [1:0]  req_ready_out,
   input  logic [89:0] req_data_in,
   output logic [43:0] line_x1_out,
   output logic [43:0] line_x2_out,
   output logic [39:0] line_y1_out,
   output logic [39:0] line_y2_out,
   output logic [3:0]  line_active_out,
   output logic        sprite_rst_out,
   output logic        frame_commit_out,
   output logic [3:0]  dirty_out
);

   typedef enum logic {RUN = 1'b0, COMMIT = 1'b1} state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic        r_last_grant;
   logic [3:0]  r_dirty;

   logic [10:0] r_sh_x1 [4];
   logic [9:0]  r_sh_y1 [4];
   logic [10:0] r_sh_x2 [4];
   logic [9:0]  r_sh_y2 [4];
   logic [3:0]  r_sh_act;

   logic [10:0] r_ac_x1 [4];
   logic [9:0]  r_ac_y1 [4];
   logic [10:0] r_ac_x2 [4];
   logic [9:0]  r_ac_y2 [4];
   logic [3:0]  r_ac_act;

   logic        w_boundary;
   logic        w_run_open;
   logic        w_commit_now;
   logic [1:0]  w_grant;
   logic        w_xfer;
   logic        w_sel;
   logic [44:0] w_req;
   logic [1:0]  w_slot;

   assign w_boundary   = (hcount_in == 11'(H_LAST)) && (vcount_in == 10'(V_LAST));
   assign w_run_open   = (r_state == RUN) && !w_boundary;
   assign w_commit_now = (r_state == RUN) && w_boundary;

   // Round-robin: on contention the requester that did not win last time goes next.
   always_comb begin
      w_grant = 2'b00;
      case (req_valid_in)
         2'b01:   w_grant = 2'b01;
         2'b10:   w_grant = 2'b10;
         2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
         default: w_grant = 2'b00;
      endcase
   end

   assign req_ready_out = w_run_open ? w_grant : 2'b00;
   assign w_xfer        = |req_ready_out;
   assign w_sel         = req_ready_out[1];
   assign w_req         = w_sel ? req_data_in[89:45] : req_data_in[44:0];
   assign w_slot        = w_req[44:43];

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) r_state <= RUN;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         RUN:     if (w_boundary) w_next_state = COMMIT;
         COMMIT:  w_next_state = RUN;
         default: w_next_state = RUN;
      endcase
   end

   // The renderer reset and commit strobe are exactly the COMMIT cycle.
   always_comb begin
      sprite_rst_out   = (r_state == COMMIT);
      frame_commit_out = (r_state == COMMIT);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_last_grant <= 1'b1;
         r_dirty      <= 4'b0000;
         r_sh_act     <= 4'b0000;
         r_ac_act     <= 4'b0000;
         for (int s = 0; s < 4; s++) begin
            r_sh_x1[s] <= '0;
            r_sh_y1[s] <= '0;
            r_sh_x2[s] <= '0;
            r_sh_y2[s] <= '0;
            r_ac_x1[s] <= '0;
            r_ac_y1[s] <= '0;
            r_ac_x2[s] <= '0;
            r_ac_y2[s] <= '0;
         end
      end else if (w_commit_now) begin
         r_dirty  <= 4'b0000;
         r_ac_act <= r_sh_act;
         for (int s = 0; s < 4; s++) begin
            r_ac_x1[s] <= r_sh_x1[s];
            r_ac_y1[s] <= r_sh_y1[s];
            r_ac_x2[s] <= r_sh_x2[s];
            r_ac_y2[s] <= r_sh_y2[s];
         end
      end else if (w_xfer) begin
         r_last_grant      <= w_sel;
         r_dirty[w_slot]   <= 1'b1;
         r_sh_act[w_slot]  <= w_req[42];
         r_sh_x1[w_slot]   <= w_req[41:31];
         r_sh_y1[w_slot]   <= w_req[30:21];
         r_sh_x2[w_slot]   <= w_req[20:10];
         r_sh_y2[w_slot]   <= w_req[9:0];
      end
   end

   always_comb begin
      line_x1_out = '0;
      line_x2_out = '0;
      line_y1_out = '0;
      line_y2_out = '0;
      for (int s = 0; s < 4; s++) begin
         line_x1_out[11*s +: 11] = r_ac_x1[s];
         line_x2_out[11*s +: 11] = r_ac_x2[s];
         line_y1_out[10*s +: 10] = r_ac_y1[s];
         line_y2_out[10*s +: 10] = r_ac_y2[s];
      end
   end

   assign line_active_out = r_ac_act;
   assign dirty_out       = r_dirty;

endmodule

// File: tb/tb_line_scheduler.sv
// Directed bench for line_scheduler: single write, contention, boundary collision,
// last-write-wins, persistence and asynchronous reset during COMMIT.
module tb_line_scheduler;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic [1:0]  req_valid_in;
   logic [1:0]  req_ready_out;
   logic [89:0] req_data_in;
   logic [43:0] line_x1_out;
   logic [43:0] line_x2_out;
   logic [39:0] line_y1_out;
   logic [39:0] line_y2_out;
   logic [3:0]  line_active_out;
   logic        sprite_rst_out;
   logic        frame_commit_out;
   logic [3:0]  dirty_out;

   int n_checks = 0;
   int n_fail   = 0;

   line_scheduler dut (
      .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .req_valid_in(req_valid_in), .req_ready_out(req_ready_out), .req_data_in(req_data_in),
      .line_x1_out(line_x1_out), .line_x2_out(line_x2_out),
      .line_y1_out(line_y1_out), .line_y2_out(line_y2_out),
      .line_active_out(line_active_out), .sprite_rst_out(sprite_rst_out),
      .frame_commit_out(frame_commit_out), .dirty_out(dirty_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [44:0] pk(input logic [1:0] slot, input logic act,
                                      input logic [10:0] x1, input logic [9:0] y1,
                                      input logic [10:0] x2, input logic [9:0] y2);
      return {slot, act, x1, y1, x2, y2};
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_boundary(input logic on);
      hcount_in = on ? 11'd1649 : 11'd0;
      vcount_in = on ? 10'd749  : 10'd0;
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
   endtask

   logic [10:0] x1v;

   initial begin
      rst_in       = 1'b1;
      req_valid_in = 2'b00;
      req_data_in  = '0;
      set_boundary(1'b0);

      // Reset state, observed before any clock edge
      #2;
      check("rst_active", line_active_out, 4'b0000);
      check("rst_dirty", dirty_out, 4'b0000);
      check("rst_sprite", sprite_rst_out, 1'b0);
      check("rst_commit", frame_commit_out, 1'b0);
      check("rst_x1", line_x1_out, 44'd0);
      tick();
      tick();
      rst_in = 1'b0;

      // Single write: requester 0, slot 2
      req_data_in[44:0] = pk(2'd2, 1'b1, 11'd100, 10'd50, 11'd300, 10'd200);
      req_valid_in = 2'b01;
      #1;
      check("single_ready", req_ready_out, 2'b01);
      tick();
      req_valid_in = 2'b00;
      check("single_dirty", dirty_out, 4'b0100);
      check("single_pre_active", line_active_out, 4'b0000);
      check("single_pre_x1", line_x1_out, 44'd0);
      set_boundary(1'b1);
      tick();
      set_boundary(1'b0);
      check("single_x1", line_x1_out[32:22], 11'd100);
      check("single_x2", line_x2_out[32:22], 11'd300);
      check("single_y1", line_y1_out[29:20], 10'd50);
      check("single_y2", line_y2_out[29:20], 10'd200);
      check("single_active", line_active_out, 4'b0100);
      check("single_sprite", sprite_rst_out, 1'b1);
      check("single_fc", frame_commit_out, 1'b1);
      check("single_dirty_clr", dirty_out, 4'b0000);
      tick();
      check("single_sprite_end", sprite_rst_out, 1'b0);
      check("single_fc_end", frame_commit_out, 1'b0);

      // Contention after reset: grants alternate 0,1,0,1
      do_reset();
      req_data_in[44:0]  = pk(2'd0, 1'b1, 11'd11, 10'd1, 11'd12, 10'd2);
      req_data_in[89:45] = pk(2'd1, 1'b1, 11'd22, 10'd3, 11'd23, 10'd4);
      req_valid_in = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("rr_grant%0d", i), req_ready_out, (i % 2 == 0) ? 2'b01 : 2'b10);
         tick();
      end

      // Boundary collision: requester 1 valid on the boundary cycle
      req_data_in[89:45] = pk(2'd2, 1'b1, 11'd33, 10'd5, 11'd34, 10'd6);
      req_valid_in = 2'b10;
      set_boundary(1'b1);
      #1;
      check("coll_ready_bnd", req_ready_out, 2'b00);
      tick();
      set_boundary(1'b0);
      check("coll_ready_commit", req_ready_out, 2'b00);
      check("coll_active", line_active_out, 4'b0011);
      check("coll_x1_s1", line_x1_out[21:11], 11'd22);
      tick();
      check("coll_ready_after", req_ready_out, 2'b10);
      tick();
      req_valid_in = 2'b00;
      check("coll_not_yet", line_active_out, 4'b0011);
      check("coll_dirty", dirty_out, 4'b0100);
      set_boundary(1'b1);
      tick();
      set_boundary(1'b0);
      check("coll_next_active", line_active_out, 4'b0111);
      check("coll_next_x1", line_x1_out[32:22], 11'd33);
      tick();

      // Last-write-wins on slot 1, plus slot 3 for persistence
      do_reset();
      req_valid_in = 2'b01;
      for (int i = 0; i < 3; i++) begin
         x1v = (i == 0) ? 11'd10 : 11'd20;
         if (i == 2) req_data_in[44:0] = pk(2'd3, 1'b1, 11'd7, 10'd8, 11'd9, 10'd10);
         else        req_data_in[44:0] = pk(2'd1, 1'b1, x1v, 10'd0, 11'd0, 10'd0);
         tick();
      end
      req_valid_in = 2'b00;
      check("lww_dirty", dirty_out, 4'b1010);
      set_boundary(1'b1);
      tick();
      set_boundary(1'b0);
      check("lww_x1", line_x1_out[21:11], 11'd20);
      check("lww_dirty_clr", dirty_out, 4'b0000);
      check("lww_active", line_active_out, 4'b1010);
      tick();
      tick();
      set_boundary(1'b1);
      tick();
      set_boundary(1'b0);
      check("persist_active", line_active_out, 4'b1010);
      check("persist_x1_s3", line_x1_out[43:33], 11'd7);
      check("persist_fc", frame_commit_out, 1'b1);

      // Asynchronous reset asserted mid-COMMIT
      #2;
      rst_in = 1'b1;
      #1;
      check("arst_active", line_active_out, 4'b0000);
      check("arst_sprite", sprite_rst_out, 1'b0);
      check("arst_fc", frame_commit_out, 1'b0);
      check("arst_x1", line_x1_out, 44'd0);
      check("arst_dirty", dirty_out, 4'b0000);
      tick();
      rst_in = 1'b0;
      tick();
      set_boundary(1'b1);
      tick();
      set_boundary(1'b0);
      check("arst_commit_fc", frame_commit_out, 1'b1);
      check("arst_commit_empty", line_active_out, 4'b0000);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/line_scheduler.md
LINE_SCHEDULER -- requirements
Module: line_scheduler

Interface
REQ-001 The block SHALL have these parameters: H_LAST, default 1649, last hcount of a frame; V_LAST, default 749, last vcount of a frame.
REQ-002 The block SHALL have these ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- hcount_in  input  11  raster column
- vcount_in  input  10  raster row
- req_valid_in  input  2  bit i: requester i presents a write
- req_ready_out  output  2  bit i: requester i write accepted this cycle
- req_data_in  input  90  requester i on bits [45i+44:45i], packed {slot[1:0], active, x1[10:0], y1[9:0], x2[10:0], y2[9:0]}
- line_x1_out  output  44  slot s on bits [11s+10:11s]
- line_x2_out  output  44  slot s on bits [11s+10:11s]
- line_y1_out  output  40  slot s on bits [10s+9:10s]
- line_y2_out  output  40  slot s on bits [10s+9:10s]
- line_active_out  output  4  per-slot enable to the line renderers
- sprite_rst_out  output  1  one-cycle reset pulse to the line renderers
- frame_commit_out  output  1  one-cycle pulse marking a frame commit
- dirty_out  output  4  slot written since the last commit
REQ-003 The block SHALL use one clock (clk_in); rst_in SHALL be asynchronous and active-high.

Function
REQ-004 The block SHALL hold a 4-slot shadow table {x1,y1,x2,y2,active} and a 4-slot active table, and SHALL drive all line_* outputs from the active table only.
REQ-005 FSM states SHALL be RUN and COMMIT; COMMIT SHALL last exactly one cycle, then return to RUN.
REQ-006 boundary SHALL be defined as (hcount_in==H_LAST && vcount_in==V_LAST).
REQ-007 In RUN with boundary=0, one requester SHALL be granted per cycle, chosen by round-robin among asserted req_valid_in bits:
- a single valid requester wins;
- if both are valid, the requester not equal to last_grant wins.
REQ-008 req_ready_out[i] SHALL be combinational and SHALL be 1 only when state==RUN, boundary==0, req_valid_in[i]==1, and i is granted; at most one bit SHALL be set per cycle.
REQ-009 On a transfer (valid&ready) from requester i, at the clock edge:
- shadow[slot] SHALL take {x1,y1,x2,y2,active} from req_data_in;
- dirty_out[slot] SHALL be set;
- last_grant SHALL become i.
REQ-010 Repeated writes to one slot within a frame SHALL leave the last write in shadow (last-write-wins).
REQ-011 In RUN with boundary=1, req_ready_out SHALL be 0, and at the clock edge:
- the active table SHALL take the full shadow table;
- dirty_out SHALL clear to 0;
- sprite_rst_out and frame_commit_out SHALL go to 1;
- state SHALL go to COMMIT.
REQ-012 In COMMIT, req_ready_out SHALL be 0; at the exit edge, sprite_rst_out and frame_commit_out SHALL return to 0.
REQ-013 Commit latency SHALL be exactly one cycle: a value written to shadow before the boundary cycle SHALL appear on line_* outputs in the cycle after the boundary cycle.
REQ-014 A write accepted at any time after the previous boundary, including the cycle immediately before the boundary cycle, SHALL be included in the commit.
REQ-015 Slots never written SHALL keep their prior shadow contents across commits (shadow is not cleared by commit).
REQ-016 A requester whose valid is held low SHALL never be granted, so there is no starvation with a single requester.
REQ-017 Coordinate fields SHALL be stored unmodified, with no ordering or normalisation; endpoint ordering is the renderer's responsibility.

Reset
REQ-018 While rst_in=1, the following SHALL be 0 immediately, independent of clk_in:
- state=RUN;
- last_grant=1, so requester 0 is favoured first;
- both tables cleared;
- line_active_out, dirty_out, sprite_rst_out, frame_commit_out all 0.
REQ-019 Reset asserted mid-frame or during COMMIT SHALL abort the commit; no partial table copy SHALL be visible after reset.
REQ-020 The first boundary after reset release SHALL commit normally.

Verification
REQ-021 Single write: requester 0 writes slot 2 {active=1, x1=100, y1=50, x2=300, y2=200}; outputs stay 0 until boundary; cycle after boundary: line_x1_out[32:22]=100, line_active_out=4'b0100, sprite_rst_out=1 for one cycle.
REQ-022 Contention: both valid every cycle after reset; grants alternate 0,1,0,1; never both ready bits set.
REQ-023 Boundary collision: requester 1 valid exactly on the boundary cycle -> ready 0 on the boundary and COMMIT cycles; accepted the next cycle; data appears one frame later.
REQ-024 Last-write-wins: slot 1 written x1=10 then x1=20 in the same frame -> committed x1=20; dirty_out=4'b0010 before commit and 0 after.
REQ-025 Async reset: assert rst_in between clock edges during COMMIT -> all outputs 0 before the next edge; the next boundary after release commits the empty table (line_active_out=0).
REQ-026 Persistence: slot 3 written in frame N, nothing written in frame N+1 -> slot 3 is still active after commit N+1.
